hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 13 +
 rtl/hazard_scoreboard_reg_match.sv | 13 +
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 tb/tb_hazard_scoreboard.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard: operand-forward selects and mult/div FSM states.
package hazard_scoreboard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_XM = 2'b01;  // operand bypassed from X/M
  localparam logic [1:0] FWD_MW = 2'b10;  // operand bypassed from M/W

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/hazard_scoreboard_reg_match.sv
// Register-address comparator; r0 is hardwired zero so it never matches.
module reg_match #(
  parameter int W = 5
) (
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         hit
);

  assign hit = en && (a == b) && (a != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, load-use and mult/div scoreboard stalls,
// plus a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] fd_rs_addr,
  input  logic [REG_ADDR_W-1:0] fd_rt_addr,
  input  logic                  fd_rs_used,
  input  logic                  fd_rt_used,
  input  logic [REG_ADDR_W-1:0] dx_rs_addr,
  input  logic [REG_ADDR_W-1:0] dx_rt_addr,
  input  logic                  dx_rs_used,
  input  logic                  dx_rt_used,
  input  logic [REG_ADDR_W-1:0] dx_rd_addr,
  input  logic                  dx_rd_wen,
  input  logic                  dx_is_load,
  input  logic [REG_ADDR_W-1:0] xm_rd_addr,
  input  logic [REG_ADDR_W-1:0] mw_rd_addr,
  input  logic                  xm_rd_wen,
  input  logic                  mw_rd_wen,
  input  logic                  md_start,
  input  logic                  md_done,
  output logic [1:0]            fwd_rs_sel,
  output logic [1:0]            fwd_rt_sel,
  output logic                  stall,
  output logic                  md_busy,
  output logic [REG_ADDR_W-1:0] md_rd,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int NREG = 2 ** REG_ADDR_W;

  md_state_e             state_q, state_d;
  logic [NREG-1:0]       pend_q, pend_d;
  logic [REG_ADDR_W-1:0] md_rd_q, md_rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic rs_xm, rs_mw, rt_xm, rt_mw, ld_rs, ld_rt;
  logic pend_rs, pend_rt, pend_waw;

  reg_match #(.W(REG_ADDR_W)) u_rs_xm (.en(dx_rs_used && xm_rd_wen), .a(dx_rs_addr), .b(xm_rd_addr), .hit(rs_xm));
  reg_match #(.W(REG_ADDR_W)) u_rs_mw (.en(dx_rs_used && mw_rd_wen), .a(dx_rs_addr), .b(mw_rd_addr), .hit(rs_mw));
  reg_match #(.W(REG_ADDR_W)) u_rt_xm (.en(dx_rt_used && xm_rd_wen), .a(dx_rt_addr), .b(xm_rd_addr), .hit(rt_xm));
  reg_match #(.W(REG_ADDR_W)) u_rt_mw (.en(dx_rt_used && mw_rd_wen), .a(dx_rt_addr), .b(mw_rd_addr), .hit(rt_mw));
  reg_match #(.W(REG_ADDR_W)) u_ld_rs (.en(fd_rs_used && dx_is_load && dx_rd_wen), .a(fd_rs_addr), .b(dx_rd_addr), .hit(ld_rs));
  reg_match #(.W(REG_ADDR_W)) u_ld_rt (.en(fd_rt_used && dx_is_load && dx_rd_wen), .a(fd_rt_addr), .b(dx_rd_addr), .hit(ld_rt));

  // Forward selects, hazard stall and busy flag; all forced quiet while in reset.
  always_comb begin
    fwd_rs_sel = FWD_RF;
    fwd_rt_sel = FWD_RF;
    pend_rs    = fd_rs_used && (fd_rs_addr != '0) && pend_q[fd_rs_addr];
    pend_rt    = fd_rt_used && (fd_rt_addr != '0) && pend_q[fd_rt_addr];
    pend_waw   = dx_rd_wen  && (dx_rd_addr != '0) && pend_q[dx_rd_addr];
    md_busy    = !reset && (state_q == MD_BUSY);
    stall      = !reset && (ld_rs || ld_rt || pend_rs || pend_rt || pend_waw ||
                            (md_start && state_q == MD_BUSY));
    if (!reset) begin
      if (rs_xm)      fwd_rs_sel = FWD_XM;
      else if (rs_mw) fwd_rs_sel = FWD_MW;
      if (rt_xm)      fwd_rt_sel = FWD_XM;
      else if (rt_mw) fwd_rt_sel = FWD_MW;
    end
  end

  // Mult/div FSM and pending bitmap; retire clears before issue sets, so equal addresses stay set.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    md_rd_d = md_rd_q;
    cnt_d   = (stall && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          state_d = MD_BUSY;
          md_rd_d = dx_rd_addr;
          if (dx_rd_addr != '0) pend_d[dx_rd_addr] = 1'b1;
        end
      end
      MD_BUSY: begin
        if (md_done) begin
          pend_d[md_rd_q] = 1'b0;
          if (md_start) begin
            md_rd_d = dx_rd_addr;
            if (dx_rd_addr != '0) pend_d[dx_rd_addr] = 1'b1;
          end else begin
            state_d = MD_IDLE;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MD_IDLE;
      pend_q  <= '0;
      md_rd_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      md_rd_q <= md_rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign md_rd       = md_rd_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: vector table, directed multi-cycle sequences, random vs. reference model.
module tb_hazard_scoreboard;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] fd_rs_addr, fd_rt_addr, dx_rs_addr, dx_rt_addr, dx_rd_addr, xm_rd_addr, mw_rd_addr;
  logic       fd_rs_used, fd_rt_used, dx_rs_used, dx_rt_used, dx_rd_wen, dx_is_load;
  logic       xm_rd_wen, mw_rd_wen, md_start, md_done;
  logic [1:0] fwd_rs_sel, fwd_rt_sel, fwd_rs_sel4, fwd_rt_sel4;
  logic       stall, md_busy, stall4, md_busy4;
  logic [4:0] md_rd, md_rd4;
  logic [31:0] stall_count;
  logic [3:0]  stall_count4;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  hazard_scoreboard dut (
    .clock(clock), .reset(reset),
    .fd_rs_addr(fd_rs_addr), .fd_rt_addr(fd_rt_addr), .fd_rs_used(fd_rs_used), .fd_rt_used(fd_rt_used),
    .dx_rs_addr(dx_rs_addr), .dx_rt_addr(dx_rt_addr), .dx_rs_used(dx_rs_used), .dx_rt_used(dx_rt_used),
    .dx_rd_addr(dx_rd_addr), .dx_rd_wen(dx_rd_wen), .dx_is_load(dx_is_load),
    .xm_rd_addr(xm_rd_addr), .mw_rd_addr(mw_rd_addr), .xm_rd_wen(xm_rd_wen), .mw_rd_wen(mw_rd_wen),
    .md_start(md_start), .md_done(md_done),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .stall(stall), .md_busy(md_busy),
    .md_rd(md_rd), .stall_count(stall_count)
  );

  hazard_scoreboard #(.REG_ADDR_W(5), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset),
    .fd_rs_addr(fd_rs_addr), .fd_rt_addr(fd_rt_addr), .fd_rs_used(fd_rs_used), .fd_rt_used(fd_rt_used),
    .dx_rs_addr(dx_rs_addr), .dx_rt_addr(dx_rt_addr), .dx_rs_used(dx_rs_used), .dx_rt_used(dx_rt_used),
    .dx_rd_addr(dx_rd_addr), .dx_rd_wen(dx_rd_wen), .dx_is_load(dx_is_load),
    .xm_rd_addr(xm_rd_addr), .mw_rd_addr(mw_rd_addr), .xm_rd_wen(xm_rd_wen), .mw_rd_wen(mw_rd_wen),
    .md_start(md_start), .md_done(md_done),
    .fwd_rs_sel(fwd_rs_sel4), .fwd_rt_sel(fwd_rt_sel4), .stall(stall4), .md_busy(md_busy4),
    .md_rd(md_rd4), .stall_count(stall_count4)
  );

  typedef struct {
    logic [4:0] dx_rs, dx_rt, xm, mw, fd_rs, fd_rt, dx_rd;
    logic       rs_u, rt_u, xm_w, mw_w, frs_u, frt_u, rd_w, ld;
    logic [1:0] e_rs, e_rt;
    logic       e_stall;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    {fd_rs_addr, fd_rt_addr, dx_rs_addr, dx_rt_addr, dx_rd_addr, xm_rd_addr, mw_rd_addr} = '0;
    {fd_rs_used, fd_rt_used, dx_rs_used, dx_rt_used, dx_rd_wen, dx_is_load} = '0;
    {xm_rd_wen, mw_rd_wen, md_start, md_done} = '0;
  endtask

  // advance one cycle: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(logic [4:0] dx_rs, logic rs_u, logic [4:0] dx_rt, logic rt_u,
                              logic [4:0] xm, logic xm_w, logic [4:0] mw, logic mw_w,
                              logic [4:0] fd_rs, logic frs_u, logic [4:0] fd_rt, logic frt_u,
                              logic [4:0] dx_rd, logic rd_w, logic ld,
                              logic [1:0] e_rs, logic [1:0] e_rt, logic e_stall);
    vec_t v;
    v.dx_rs = dx_rs; v.rs_u = rs_u; v.dx_rt = dx_rt; v.rt_u = rt_u;
    v.xm = xm; v.xm_w = xm_w; v.mw = mw; v.mw_w = mw_w;
    v.fd_rs = fd_rs; v.frs_u = frs_u; v.fd_rt = fd_rt; v.frt_u = frt_u;
    v.dx_rd = dx_rd; v.rd_w = rd_w; v.ld = ld;
    v.e_rs = e_rs; v.e_rt = e_rt; v.e_stall = e_stall;
    return v;
  endfunction

  // reference model state: at most one register awaits a mult/div result
  bit      m_busy;
  int      m_rd;
  longint  m_cnt;

  function automatic int fsel(int src, bit used);
    if (!used || src == 0) return 0;
    if (xm_rd_wen && int'(xm_rd_addr) == src) return 1;
    if (mw_rd_wen && int'(mw_rd_addr) == src) return 2;
    return 0;
  endfunction

  function automatic bit waiting_on(int r);
    return m_busy && m_rd != 0 && r == m_rd;
  endfunction

  function automatic bit m_stall();
    bit s;
    s = 0;
    if (dx_is_load && dx_rd_wen && dx_rd_addr != 0) begin
      if (fd_rs_used && fd_rs_addr == dx_rd_addr) s = 1;
      if (fd_rt_used && fd_rt_addr == dx_rd_addr) s = 1;
    end
    if (fd_rs_used && waiting_on(int'(fd_rs_addr))) s = 1;
    if (fd_rt_used && waiting_on(int'(fd_rt_addr))) s = 1;
    if (dx_rd_wen && waiting_on(int'(dx_rd_addr))) s = 1;
    if (md_start && m_busy) s = 1;
    return s && !reset;
  endfunction

  initial begin
    reset = 1'b1;
    clr();

    // reset state, with hazardous inputs present
    tick();
    dx_rs_addr = 3; dx_rs_used = 1; xm_rd_addr = 3; xm_rd_wen = 1;
    dx_is_load = 1; dx_rd_wen = 1; dx_rd_addr = 5; fd_rt_addr = 5; fd_rt_used = 1; md_start = 1;
    @(negedge clock);
    chk("rst_fwd_rs", 32'(fwd_rs_sel), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", 32'(md_busy), 0);
    chk("rst_md_rd", 32'(md_rd), 0);
    chk("rst_cnt", stall_count, 0);
    tick();
    chk("rst_busy2", 32'(md_busy), 0);
    reset = 1'b0;
    clr();

    // combinational forwarding / load-use vector table (scoreboard empty)
    vt[0]  = mk(3,1, 0,0, 3,1, 3,1, 0,0, 0,0, 0,0,0, 2'b01, 2'b00, 0);
    vt[1]  = mk(0,0, 0,1, 0,1, 0,0, 0,0, 0,0, 0,0,0, 2'b00, 2'b00, 0);
    vt[2]  = mk(4,1, 0,0, 5,1, 4,1, 0,0, 0,0, 0,0,0, 2'b10, 2'b00, 0);
    vt[3]  = mk(4,0, 0,0, 4,1, 0,0, 0,0, 0,0, 0,0,0, 2'b00, 2'b00, 0);
    vt[4]  = mk(0,0, 6,1, 6,0, 6,1, 0,0, 0,0, 0,0,0, 2'b00, 2'b10, 0);
    vt[5]  = mk(2,1, 2,1, 2,1, 9,1, 0,0, 0,0, 0,0,0, 2'b01, 2'b01, 0);
    vt[6]  = mk(0,0, 0,0, 0,0, 0,0, 0,0, 5,1, 5,1,1, 2'b00, 2'b00, 1);
    vt[7]  = mk(0,0, 0,0, 0,0, 0,0, 0,0, 5,0, 5,1,1, 2'b00, 2'b00, 0);
    vt[8]  = mk(0,0, 0,0, 0,0, 0,0, 5,1, 0,0, 5,1,0, 2'b00, 2'b00, 0);
    vt[9]  = mk(0,0, 0,0, 0,0, 0,0, 0,1, 0,0, 0,1,1, 2'b00, 2'b00, 0);
    vt[10] = mk(0,0, 0,0, 0,0, 0,0, 5,1, 0,0, 5,0,1, 2'b00, 2'b00, 0);
    for (int i = 0; i < 11; i++) begin
      clr();
      dx_rs_addr = vt[i].dx_rs; dx_rs_used = vt[i].rs_u; dx_rt_addr = vt[i].dx_rt; dx_rt_used = vt[i].rt_u;
      xm_rd_addr = vt[i].xm; xm_rd_wen = vt[i].xm_w; mw_rd_addr = vt[i].mw; mw_rd_wen = vt[i].mw_w;
      fd_rs_addr = vt[i].fd_rs; fd_rs_used = vt[i].frs_u; fd_rt_addr = vt[i].fd_rt; fd_rt_used = vt[i].frt_u;
      dx_rd_addr = vt[i].dx_rd; dx_rd_wen = vt[i].rd_w; dx_is_load = vt[i].ld;
      @(negedge clock);
      chk($sformatf("vec%0d_rs", i), 32'(fwd_rs_sel), 32'(vt[i].e_rs));
      chk($sformatf("vec%0d_rt", i), 32'(fwd_rt_sel), 32'(vt[i].e_rt));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vt[i].e_stall));
      tick();
    end

    // load-use: single stall cycle, counter 0 -> 1
    do_reset();
    dx_is_load = 1; dx_rd_wen = 1; dx_rd_addr = 5; fd_rt_addr = 5; fd_rt_used = 1;
    @(negedge clock);
    chk("lu_stall", 32'(stall), 1);
    chk("lu_cnt0", stall_count, 0);
    tick();
    clr(); fd_rt_addr = 5; fd_rt_used = 1;
    @(negedge clock);
    chk("lu_stall_after", 32'(stall), 0);
    chk("lu_cnt1", stall_count, 1);
    tick();

    // mult/div RAW on r7 for 4 cycles, retire in cycle 4
    do_reset();
    md_start = 1; dx_rd_addr = 7; dx_rd_wen = 1;
    @(negedge clock);
    chk("md_c0_stall", 32'(stall), 0);
    chk("md_c0_busy", 32'(md_busy), 0);
    tick();
    clr(); fd_rs_addr = 7; fd_rs_used = 1;
    for (int c = 1; c <= 4; c++) begin
      md_done = (c == 4);
      @(negedge clock);
      chk($sformatf("md_c%0d_stall", c), 32'(stall), 1);
      chk($sformatf("md_c%0d_busy", c), 32'(md_busy), 1);
      chk($sformatf("md_c%0d_rd", c), 32'(md_rd), 7);
      tick();
    end
    md_done = 0;
    @(negedge clock);
    chk("md_c5_stall", 32'(stall), 0);
    chk("md_c5_busy", 32'(md_busy), 0);
    chk("md_cnt", stall_count, 4);
    tick();

    // back-to-back: retire r7 and issue r9 in one cycle, then reissue r9 over itself
    do_reset();
    md_start = 1; dx_rd_addr = 7;
    tick();
    md_done = 1; md_start = 1; dx_rd_addr = 9;
    @(negedge clock);
    chk("b2b_stall", 32'(stall), 1);
    tick();
    clr();
    @(negedge clock);
    chk("b2b_busy", 32'(md_busy), 1);
    chk("b2b_rd", 32'(md_rd), 9);
    fd_rs_addr = 7; fd_rs_used = 1;
    #1 chk("b2b_r7_free", 32'(stall), 0);
    fd_rs_addr = 9;
    #1 chk("b2b_r9_pend", 32'(stall), 1);
    tick();
    clr(); md_done = 1; md_start = 1; dx_rd_addr = 9;
    tick();
    clr(); fd_rt_addr = 9; fd_rt_used = 1;
    @(negedge clock);
    chk("same_r9_pend", 32'(stall), 1);
    chk("same_busy", 32'(md_busy), 1);
    tick();

    // reset while busy on r4 discards the pending entry
    do_reset();
    md_start = 1; dx_rd_addr = 4;
    tick();
    clr(); fd_rs_addr = 4; fd_rs_used = 1;
    @(negedge clock);
    chk("rb_pre_stall", 32'(stall), 1);
    tick();
    reset = 1;
    @(negedge clock);
    chk("rb_in_rst_stall", 32'(stall), 0);
    chk("rb_in_rst_busy", 32'(md_busy), 0);
    tick();
    reset = 0;
    @(negedge clock);
    chk("rb_busy", 32'(md_busy), 0);
    chk("rb_stall", 32'(stall), 0);
    chk("rb_cnt", stall_count, 0);
    tick();

    // md_done in IDLE ignored; md_start to r0 goes busy with nothing pending
    do_reset();
    md_done = 1;
    tick();
    clr();
    @(negedge clock);
    chk("idle_done_busy", 32'(md_busy), 0);
    md_start = 1; dx_rd_addr = 0;
    tick();
    clr(); fd_rs_addr = 0; fd_rs_used = 1; dx_rd_wen = 1;
    @(negedge clock);
    chk("r0_busy", 32'(md_busy), 1);
    chk("r0_stall", 32'(stall), 0);
    tick();

    // 20 forced stalls: 4-bit counter saturates at 15
    do_reset();
    dx_is_load = 1; dx_rd_wen = 1; dx_rd_addr = 5; fd_rs_addr = 5; fd_rs_used = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 14) chk("sat_at15", 32'(stall_count4), 15);
    end
    clr();
    @(negedge clock);
    chk("sat_hold", 32'(stall_count4), 15);
    chk("sat_wide", stall_count, 20);
    tick();

    // randomized traffic against the reference model
    do_reset();
    m_busy = 0; m_rd = 0; m_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 49) == 0);
      fd_rs_addr = 5'($urandom_range(0, 3)); fd_rs_used = 1'($urandom);
      fd_rt_addr = 5'($urandom_range(0, 3)); fd_rt_used = 1'($urandom);
      dx_rs_addr = 5'($urandom_range(0, 3)); dx_rs_used = 1'($urandom);
      dx_rt_addr = 5'($urandom_range(0, 3)); dx_rt_used = 1'($urandom);
      dx_rd_addr = 5'($urandom_range(0, 3)); dx_rd_wen  = 1'($urandom);
      dx_is_load = 1'($urandom);
      xm_rd_addr = 5'($urandom_range(0, 3)); xm_rd_wen  = 1'($urandom);
      mw_rd_addr = 5'($urandom_range(0, 3)); mw_rd_wen  = 1'($urandom);
      md_start   = ($urandom_range(0, 5) == 0);
      md_done    = ($urandom_range(0, 3) == 0);
      @(negedge clock);
      chk("rnd_fwd_rs", 32'(fwd_rs_sel), reset ? 0 : 32'(fsel(int'(dx_rs_addr), dx_rs_used)));
      chk("rnd_fwd_rt", 32'(fwd_rt_sel), reset ? 0 : 32'(fsel(int'(dx_rt_addr), dx_rt_used)));
      chk("rnd_stall", 32'(stall), 32'(m_stall()));
      chk("rnd_busy", 32'(md_busy), 32'(m_busy && !reset));
      chk("rnd_md_rd", 32'(md_rd), 32'(m_rd));
      chk("rnd_cnt", stall_count, 32'(m_cnt));
      if (reset) begin
        m_busy = 0; m_rd = 0; m_cnt = 0;
      end else begin
        if (m_stall() && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (!m_busy) begin
          if (md_start) begin m_busy = 1; m_rd = int'(dx_rd_addr); end
        end else if (md_done) begin
          if (md_start) m_rd = int'(dx_rd_addr);
          else m_busy = 0;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
